acm_coord_mapper: RTL

Parametrised Arnold's Cat Map coordinate engine for the ACM encryptor/decryptor datapath. For a dim_p × dim_p image it walks every pixel in raster order and applies K forward (encrypt) or inverse (decrypt) cat-map iterations. It then emits (source, mapped) coordinate pairs over a valid/ready stream. The downstream pixel-cell array uses these pairs as its address stream.

---
 rtl/acm_pkg.sv | 8 +
 rtl/acm_coord_step.sv | 57 +++++
 rtl/acm_coord_mapper.sv | 128 ++++++++++++
 3 files changed

// File: rtl/acm_pkg.sv
// Shared types for the Arnold's Cat Map coordinate engine.
package acm_pkg;

   typedef enum logic [1:0] {IDLE, MAP, OUT} acm_map_state_e;

   typedef enum logic {ACM_ENC, ACM_DEC} acm_mode_e;

endpackage

// File: rtl/acm_coord_step.sv
// One combinational cat-map iteration (forward or inverse) modulo dim_p.
// Reduction uses conditional add/subtract of N only; no divider.
module acm_coord_step
   import acm_pkg::*;
#(
   parameter  int dim_p          = 64,
   localparam int coord_width_lp = $clog2(dim_p)
) (
   input  logic [coord_width_lp-1:0] xm_i,
   input  logic [coord_width_lp-1:0] ym_i,
   input  logic                      decrypt_i,
   output logic [coord_width_lp-1:0] xm_o,
   output logic [coord_width_lp-1:0] ym_o
);

   localparam int W = coord_width_lp;
   localparam logic        [W+1:0] N_U = (W+2)'(dim_p);
   localparam logic signed [W+2:0] N_S = (W+3)'(dim_p);

   // x+y < 2N, so one conditional subtract suffices
   function automatic logic [W-1:0] fwd_x(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W+1:0] s;
      s = {2'b00, a} + {2'b00, b};
      if (s >= N_U) s = s - N_U;
      return s[W-1:0];
   endfunction

   // x+2y < 3N, so up to two conditional subtracts
   function automatic logic [W-1:0] fwd_y(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W+1:0] s;
      s = {2'b00, a} + {1'b0, b, 1'b0};
      if (s >= N_U) s = s - N_U;
      if (s >= N_U) s = s - N_U;
      return s[W-1:0];
   endfunction

   // 2x-y lies in (-N, 2N)
   function automatic logic [W-1:0] inv_x(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W+2:0] d;
      d = $signed({2'b00, a, 1'b0}) - $signed({3'b000, b});
      if (d < 0)         d = d + N_S;
      else if (d >= N_S) d = d - N_S;
      return d[W-1:0];
   endfunction

   // y-x lies in (-N, N)
   function automatic logic [W-1:0] inv_y(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W+2:0] d;
      d = $signed({3'b000, b}) - $signed({3'b000, a});
      if (d < 0) d = d + N_S;
      return d[W-1:0];
   endfunction

   assign xm_o = decrypt_i ? inv_x(xm_i, ym_i) : fwd_x(xm_i, ym_i);
   assign ym_o = decrypt_i ? inv_y(xm_i, ym_i) : fwd_y(xm_i, ym_i);

endmodule

// File: rtl/acm_coord_mapper.sv
// Raster-walks an N x N image, applies K cat-map iterations per pixel and
// streams (source, mapped) coordinate pairs over valid/ready.
module acm_coord_mapper
   import acm_pkg::*;
#(
   parameter  int dim_p          = 64,
   parameter  int iter_width_p   = 8,
   localparam int coord_width_lp = $clog2(dim_p)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_v_i,
   output logic                      start_ready_o,
   input  logic [iter_width_p-1:0]   iters_i,
   input  logic                      decrypt_i,
   output logic                      v_o,
   input  logic                      ready_i,
   output logic [coord_width_lp-1:0] x_o,
   output logic [coord_width_lp-1:0] y_o,
   output logic [coord_width_lp-1:0] xm_o,
   output logic [coord_width_lp-1:0] ym_o,
   output logic                      last_o,
   output logic                      done_o
);

   localparam int W = coord_width_lp;
   localparam logic [W-1:0]            LAST_C = W'(dim_p - 1);
   localparam logic [iter_width_p-1:0] ONE_K  = iter_width_p'(1);

   acm_map_state_e          r_state, w_state_nxt;
   acm_mode_e               r_mode;
   logic [iter_width_p-1:0] r_k, r_cnt;
   logic [W-1:0]            r_x, r_y, r_xm, r_ym;
   logic [W-1:0]            w_xm_step, w_ym_step, w_x_nxt, w_y_nxt;
   logic                    r_done, w_accept, w_advance, w_finish, w_at_last;

   acm_coord_step #(.dim_p(dim_p)) u_step (
      .xm_i      (r_xm),
      .ym_i      (r_ym),
      .decrypt_i (r_mode == ACM_DEC),
      .xm_o      (w_xm_step),
      .ym_o      (w_ym_step)
   );

   assign w_at_last = (r_x == LAST_C) && (r_y == LAST_C);
   assign w_x_nxt   = (r_x == LAST_C) ? '0 : r_x + 1'b1;
   assign w_y_nxt   = (r_x == LAST_C) ? r_y + 1'b1 : r_y;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_v_i) begin
               w_accept    = 1'b1;
               w_state_nxt = (iters_i != '0) ? MAP : OUT;
            end
         end
         MAP: begin
            if (r_cnt == ONE_K) w_state_nxt = OUT;
         end
         OUT: begin
            if (ready_i) begin
               if (w_at_last) begin
                  w_finish    = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_advance   = 1'b1;
                  w_state_nxt = (r_k != '0) ? MAP : OUT;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: job setup, iteration, and raster advance
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode <= ACM_ENC;
         r_k    <= '0;
         r_cnt  <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_xm   <= '0;
         r_ym   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_mode <= decrypt_i ? ACM_DEC : ACM_ENC;
            r_k    <= iters_i;
            r_cnt  <= iters_i;
            r_x    <= '0;
            r_y    <= '0;
            r_xm   <= '0;
            r_ym   <= '0;
         end else if (r_state == MAP) begin
            r_xm  <= w_xm_step;
            r_ym  <= w_ym_step;
            r_cnt <= r_cnt - 1'b1;
         end else if (w_advance) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_xm  <= w_x_nxt;
            r_ym  <= w_y_nxt;
            r_cnt <= r_k;
         end
      end
   end

   assign start_ready_o = (r_state == IDLE);
   assign v_o           = (r_state == OUT);
   assign last_o        = (r_state == OUT) && w_at_last;
   assign done_o        = r_done;
   assign x_o           = r_x;
   assign y_o           = r_y;
   assign xm_o          = r_xm;
   assign ym_o          = r_ym;

endmodule
